// File: rtl/counter_pkg.sv
// Shared definitions for the reciprocal gate counter: FSM encoding, phase
// resolution and the 1/8-cycle interpolation helper.
package counter_pkg;

    localparam int PHASES     = 8;
    localparam int PHASE_BITS = $clog2(PHASES);
    localparam int CNT_W_DEF  = 32;
    localparam int PER_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Difference taken one bit wider than the phase code so it lands in -7..+7.
    function automatic logic [PHASE_BITS:0] phase_diff(
        input logic [PHASE_BITS-1:0] stop_ph,
        input logic [PHASE_BITS-1:0] start_ph
    );
        return {1'b0, stop_ph} - {1'b0, start_ph};
    endfunction

endpackage

// File: rtl/recip_gate_counter_if.sv
// Control/result bundle between the edge sampler, the gate counter and the
// count adder.
interface recip_gate_counter_if #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) ();
    import counter_pkg::*;

    logic                  start;
    logic [PER_W-1:0]      gate_periods;
    logic                  edge_stb;
    logic [PHASE_BITS-1:0] edge_phase;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic                  overflow;
    logic [CNT_W-1:0]      recip_count;
    logic [CNT_W-1:0]      fine_count;

    modport slave (
        input  start, gate_periods, edge_stb, edge_phase,
        output busy, done, timeout, overflow, recip_count, fine_count
    );

    modport master (
        output start, gate_periods, edge_stb, edge_phase,
        input  busy, done, timeout, overflow, recip_count, fine_count
    );

endinterface

// File: rtl/recip_sat_counter.sv
// Clearable, enabled up-counter that sticks at all-ones and flags saturation.
module recip_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_sat) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = w_sat;

endmodule

// File: rtl/recip_gate_counter.sv
// Reciprocal gate measurement: spans N input periods, reporting a coarse clk
// count plus a signed 1/8-cycle correction from the edge phase codes.
module recip_gate_counter
    import counter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PER_W       = PER_W_DEF,
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    recip_gate_counter_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [PER_W-1:0]      r_n;
    logic [PER_W-1:0]      r_per_cnt;
    logic [PHASE_BITS-1:0] r_start_phase;
    logic                  r_timeout;
    logic                  r_overflow;
    logic [CNT_W-1:0]      r_recip;
    logic [CNT_W-1:0]      r_fine;

    logic                  w_busy;
    logic                  w_start_acc;
    logic                  w_arm_edge;
    logic                  w_stop_edge;
    logic                  w_to_hit;
    logic [CNT_W-1:0]      w_coarse;
    logic                  w_coarse_sat;
    logic [TO_W-1:0]       w_to_cnt;
    logic                  w_to_sat;
    logic [PHASE_BITS:0]   w_fine_s;

    assign w_busy      = (r_state == ST_ARM) || (r_state == ST_COUNT);
    assign w_start_acc = (r_state == ST_IDLE) && bus.start;
    assign w_arm_edge  = (r_state == ST_ARM) && bus.edge_stb;
    assign w_stop_edge = (r_state == ST_COUNT) && bus.edge_stb
                         && ((r_per_cnt + PER_W'(1)) == r_n);
    assign w_to_hit    = w_busy && !bus.edge_stb
                         && ((w_to_cnt == TO_W'(TIMEOUT_CYC - 1)) || w_to_sat);
    assign w_fine_s    = phase_diff(bus.edge_phase, r_start_phase);

    // Coarse count is zero in the cycle after the start edge, so +1 at the stop edge.
    recip_sat_counter #(.W(CNT_W)) u_coarse (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_arm_edge),
        .i_en  (r_state == ST_COUNT),
        .o_cnt (w_coarse),
        .o_sat (w_coarse_sat)
    );

    recip_sat_counter #(.W(TO_W)) u_idle (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (!w_busy || bus.edge_stb),
        .i_en  (w_busy),
        .o_cnt (w_to_cnt),
        .o_sat (w_to_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_ARM;
            ST_ARM: begin
                if (w_to_hit)          w_state_next = ST_DONE;
                else if (bus.edge_stb) w_state_next = ST_COUNT;
            end
            ST_COUNT: if (w_stop_edge || w_to_hit) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n           <= '0;
            r_per_cnt     <= '0;
            r_start_phase <= '0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
            r_recip       <= '0;
            r_fine        <= '0;
        end else begin
            if (w_start_acc) begin
                r_n        <= (bus.gate_periods == '0) ? PER_W'(1) : bus.gate_periods;
                r_timeout  <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (w_arm_edge) begin
                r_start_phase <= bus.edge_phase;
                r_per_cnt     <= '0;
            end else if ((r_state == ST_COUNT) && bus.edge_stb) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end
            if (w_stop_edge) begin
                r_recip    <= w_coarse_sat ? '1 : (w_coarse + CNT_W'(1));
                r_fine     <= {{(CNT_W-PHASE_BITS-1){w_fine_s[PHASE_BITS]}}, w_fine_s};
                r_overflow <= w_coarse_sat;
                r_timeout  <= 1'b0;
            end else if (w_to_hit) begin
                r_recip    <= '0;
                r_fine     <= '0;
                r_overflow <= 1'b0;
                r_timeout  <= 1'b1;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = (r_state == ST_DONE);
    assign bus.timeout     = r_timeout;
    assign bus.overflow    = r_overflow;
    assign bus.recip_count = r_recip;
    assign bus.fine_count  = r_fine;

endmodule

// File: tb/tb_recip_gate_counter.sv
// Directed bench for recip_gate_counter: hand-computed gate measurements,
// timeout, ignored starts/edges and mid-measurement reset.
module tb_recip_gate_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    recip_gate_counter_if #(.CNT_W(32), .PER_W(16)) bif ();

    recip_gate_counter #(
        .CNT_W       (32),
        .PER_W       (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  {31'd0, bif.busy},     32'd0);
        check_eq({tag, "_done"},  {31'd0, bif.done},     32'd0);
        check_eq({tag, "_to"},    {31'd0, bif.timeout},  32'd0);
        check_eq({tag, "_ovf"},   {31'd0, bif.overflow}, 32'd0);
        check_eq({tag, "_recip"}, bif.recip_count,       32'd0);
        check_eq({tag, "_fine"},  bif.fine_count,        32'd0);
    endtask

    // Start edge 3 cycles after start, then n_per edges every 'period' cycles.
    task automatic measure(input string tag, input logic [15:0] gp, input int period,
                           input logic [2:0] ph0, input logic [2:0] ph1, input int n_per,
                           input bit extra, input logic [31:0] exp_recip,
                           input logic [31:0] exp_fine);
        int early_done = 0;
        bif.start = 1'b1;
        bif.gate_periods = gp;
        bif.edge_stb = extra;
        bif.edge_phase = 3'd7;
        tick();
        bif.start = 1'b0;
        bif.edge_stb = 1'b0;
        bif.gate_periods = 16'd1;
        check_eq({tag, "_busy_arm"}, {31'd0, bif.busy}, 32'd1);
        check_eq({tag, "_flags_clr"}, {30'd0, bif.timeout, bif.overflow}, 32'd0);
        repeat (2) tick();
        bif.edge_stb = 1'b1;
        bif.edge_phase = ph0;
        tick();
        bif.edge_stb = 1'b0;
        for (int e = 1; e <= n_per; e++) begin
            for (int c = 1; c < period; c++) begin
                bif.start = extra && (e == 2) && (c == 3);
                tick();
                bif.start = 1'b0;
                if (bif.done || !bif.busy) early_done++;
            end
            bif.edge_stb = 1'b1;
            bif.edge_phase = (e == n_per) ? ph1 : 3'd4;
            tick();
            bif.edge_stb = 1'b0;
            if (e < n_per && bif.done) early_done++;
        end
        check_eq({tag, "_no_early_done"}, early_done, 32'd0);
        check_eq({tag, "_done"},  {31'd0, bif.done},     32'd1);
        check_eq({tag, "_recip"}, bif.recip_count,       exp_recip);
        check_eq({tag, "_fine"},  bif.fine_count,        exp_fine);
        check_eq({tag, "_final"}, (bif.recip_count << 3) + bif.fine_count,
                 (exp_recip << 3) + exp_fine);
        check_eq({tag, "_to"},    {31'd0, bif.timeout},  32'd0);
        check_eq({tag, "_ovf"},   {31'd0, bif.overflow}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, bif.busy},     32'd0);
        $display("meas %s: recip=%0d fine=0x%08h", tag, bif.recip_count, bif.fine_count);
        tick();
        check_eq({tag, "_done_1cyc"}, {31'd0, bif.done}, 32'd0);
        bif.edge_stb = 1'b1;
        bif.edge_phase = 3'd3;
        tick();
        bif.edge_stb = 1'b0;
        tick();
        check_eq({tag, "_idle_edge_busy"}, {31'd0, bif.busy}, 32'd0);
        check_eq({tag, "_held_recip"}, bif.recip_count, exp_recip);
        check_eq({tag, "_held_fine"},  bif.fine_count,  exp_fine);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bif.start = 1'b0;
        bif.gate_periods = 16'd0;
        bif.edge_stb = 1'b0;
        bif.edge_phase = 3'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        measure("case1", 16'd4, 10, 3'd2, 3'd5, 4, 1'b0, 32'd40, 32'd3);
        measure("case2", 16'd4, 10, 3'd6, 3'd1, 4, 1'b0, 32'd40, 32'hFFFF_FFFB);
        measure("case3", 16'd0, 7,  3'd1, 3'd1, 1, 1'b0, 32'd7,  32'd0);

        // Timeout: no edges after start, busy for exactly TIMEOUT_CYC cycles
        bif.start = 1'b1;
        bif.gate_periods = 16'd3;
        tick();
        bif.start = 1'b0;
        cnt = 0;
        while (bif.busy && cnt < 200) begin
            cnt++;
            tick();
        end
        check_eq("to_busy_cycles", cnt, 32'd100);
        check_eq("to_done",  {31'd0, bif.done},     32'd1);
        check_eq("to_flag",  {31'd0, bif.timeout},  32'd1);
        check_eq("to_recip", bif.recip_count,       32'd0);
        check_eq("to_fine",  bif.fine_count,        32'd0);
        check_eq("to_ovf",   {31'd0, bif.overflow}, 32'd0);
        $display("meas timeout: busy_cycles=%0d timeout=%0b", cnt, bif.timeout);
        tick();
        check_eq("to_done_1cyc", {31'd0, bif.done},    32'd0);
        check_eq("to_held",      {31'd0, bif.timeout}, 32'd1);

        measure("case5", 16'd4, 10, 3'd2, 3'd5, 4, 1'b1, 32'd40, 32'd3);

        // Reset while counting
        bif.start = 1'b1;
        bif.gate_periods = 16'd4;
        tick();
        bif.start = 1'b0;
        repeat (2) tick();
        bif.edge_stb = 1'b1;
        bif.edge_phase = 3'd2;
        tick();
        bif.edge_stb = 1'b0;
        repeat (12) tick();
        check_eq("rst_pre_busy", {31'd0, bif.busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("rst_mid");
        cnt = 0;
        repeat (5) begin
            tick();
            if (bif.done || bif.busy) cnt++;
        end
        check_eq("rst_no_done", cnt, 32'd0);
        $display("meas reset: outputs cleared");

        measure("case6", 16'd4, 10, 3'd2, 3'd5, 4, 1'b0, 32'd40, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
